onehot_to_bin_stream: RTL and testbench



---
 rtl/oh2bin_pkg.sv | 20 ++
 rtl/oh_prienc.sv | 42 ++++
 rtl/onehot_to_bin_stream.sv | 160 ++++++++++++++++
 tb/tb_onehot_to_bin_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oh2bin_pkg.sv
// -----------------------------------------------------------------------------
// oh2bin_pkg
// Shared types and helpers for the one-hot to binary stream decoder.
//   err_kind_e : classification of an input vector (none / zero-hot / multi-hot)
//   min_bin_w  : smallest binary width able to index a one-hot vector
// -----------------------------------------------------------------------------
package oh2bin_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ZERO  = 2'd1,
    ERR_MULTI = 2'd2
  } err_kind_e;

  // Minimum index width for a one-hot vector of the given width.
  function automatic int min_bin_w(input int one_hot_w);
    return (one_hot_w > 1) ? $clog2(one_hot_w) : 1;
  endfunction

endpackage

// File: rtl/oh_prienc.sv
// -----------------------------------------------------------------------------
// oh_prienc
// Purely combinational lowest-set-bit priority encoder with population flags.
// Ports:
//   vec       in  [ONE_HOT_W-1:0]  vector to encode
//   idx       out [BIN_W-1:0]      index of the lowest set bit (0 when none set)
//   any_set   out                  at least one bit is set
//   multi_set out                  two or more bits are set
// -----------------------------------------------------------------------------
module oh_prienc
  import oh2bin_pkg::*;
#(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4
) (
  input  logic [ONE_HOT_W-1:0] vec,
  output logic [BIN_W-1:0]     idx,
  output logic                 any_set,
  output logic                 multi_set
);

  localparam logic [ONE_HOT_W-1:0] VEC_ONE = ONE_HOT_W'(1);

  logic [BIN_W-1:0] idx_s;
  logic             found_s;

  // Scan from bit 0 upward; the first set bit wins and later ones are ignored.
  always_comb begin
    idx_s   = {BIN_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      idx_s   = (vec[i] && !found_s) ? BIN_W'(i) : idx_s;
      found_s = found_s | vec[i];
    end
  end

  assign idx     = idx_s;
  assign any_set = |vec;
  // Clearing the lowest set bit leaves something only if more than one was set.
  assign multi_set = |(vec & (vec - VEC_ONE));

endmodule

// File: rtl/onehot_to_bin_stream.sv
// -----------------------------------------------------------------------------
// onehot_to_bin_stream
// Streaming one-hot to binary decoder with a two-stage elastic pipeline.
// S1 registers the raw vector, the encoder sits between S1 and S2, and S2
// drives the outputs. Non-one-hot inputs are flagged per beat and counted.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   oh_valid_i   in   input beat valid
//   oh_ready_o   out  input beat can be accepted this cycle
//   one_hot_i    in   [ONE_HOT_W-1:0] one-hot vector
//   bin_valid_o  out  output beat valid
//   bin_ready_i  in   downstream accepts the output beat
//   bin_o        out  [BIN_W-1:0] binary index (lowest set bit)
//   err_o        out  output beat came from a non-one-hot vector
//   err_kind_o   out  [1:0] 0 none, 1 zero-hot, 2 multi-hot
//   err_cnt_o    out  [ERR_CNT_W-1:0] saturating count of erroneous transfers
//   err_clr_i    in   synchronous clear of err_cnt_o
// -----------------------------------------------------------------------------
module onehot_to_bin_stream
  import oh2bin_pkg::*;
#(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 oh_valid_i,
  output logic                 oh_ready_o,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 bin_valid_o,
  input  logic                 bin_ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic [1:0]           err_kind_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  generate
    if (ONE_HOT_W < 2 || BIN_W < min_bin_w(ONE_HOT_W)) begin : g_bad_param
      $error("onehot_to_bin_stream: ONE_HOT_W must be >= 2 and BIN_W >= clog2(ONE_HOT_W)");
    end
  endgenerate

  localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  // Stage registers
  logic                 s1_valid_r;
  logic [ONE_HOT_W-1:0] s1_vec_r;
  logic                 s2_valid_r;
  logic [BIN_W-1:0]     bin_r;
  logic                 err_r;
  err_kind_e            kind_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Handshake and encoder signals
  logic                 s2_load_s;
  logic                 s1_load_s;
  logic                 err_xfer_s;
  logic [BIN_W-1:0]     enc_idx_s;
  logic                 enc_any_s;
  logic                 enc_multi_s;
  logic                 enc_err_s;
  err_kind_e            enc_kind_s;

  // A stage advances when it is empty or its successor advances, so a full
  // pipeline with a ready consumer accepts and drains in the same cycle.
  assign s2_load_s  = !s2_valid_r || bin_ready_i;
  assign s1_load_s  = !s1_valid_r || s2_load_s;
  assign err_xfer_s = s2_valid_r && bin_ready_i && err_r;

  oh_prienc #(
    .ONE_HOT_W (ONE_HOT_W),
    .BIN_W     (BIN_W)
  ) u_prienc (
    .vec       (s1_vec_r),
    .idx       (enc_idx_s),
    .any_set   (enc_any_s),
    .multi_set (enc_multi_s)
  );

  // Classify the S1 vector; the zero-hot index falls out of the encoder as 0.
  always_comb begin
    enc_kind_s = ERR_NONE;
    enc_err_s  = 1'b0;
    case ({enc_any_s, enc_multi_s})
      2'b10: begin
        enc_kind_s = ERR_NONE;
        enc_err_s  = 1'b0;
      end
      2'b11: begin
        enc_kind_s = ERR_MULTI;
        enc_err_s  = 1'b1;
      end
      2'b00: begin
        enc_kind_s = ERR_ZERO;
        enc_err_s  = 1'b1;
      end
      default: begin
        enc_kind_s = ERR_NONE;
        enc_err_s  = 1'b0;
      end
    endcase
  end

  // S1: capture the raw vector whenever the stage may advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_vec_r   <= {ONE_HOT_W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= oh_valid_i;
      if (oh_valid_i) begin
        s1_vec_r <= one_hot_i;
      end
    end
  end

  // S2: results only change when a real beat moves in, so an empty pipeline
  // keeps the last beat's values on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      bin_r      <= {BIN_W{1'b0}};
      err_r      <= 1'b0;
      kind_r     <= ERR_NONE;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        bin_r  <= enc_idx_s;
        err_r  <= enc_err_s;
        kind_r <= enc_kind_s;
      end
    end
  end

  // Error counter: a clear coincident with an erroneous transfer keeps that
  // error by restarting at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= CNT_ZERO;
    end else if (err_clr_i) begin
      err_cnt_r <= err_xfer_s ? CNT_ONE : CNT_ZERO;
    end else if (err_xfer_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end
  end

  assign oh_ready_o  = s1_load_s;
  assign bin_valid_o = s2_valid_r;
  assign bin_o       = bin_r;
  assign err_o       = err_r;
  assign err_kind_o  = kind_r;
  assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// -----------------------------------------------------------------------------
// tb_onehot_to_bin_stream
// Self-checking bench: table-driven directed vectors, hand-written corner
// sequences and a long randomized valid/ready run against a queue-based
// reference model. A second instance with a 2-bit error counter shares the
// stimulus so counter saturation is observed alongside the main instance.
// -----------------------------------------------------------------------------
module tb_onehot_to_bin_stream;

  logic        clk;
  logic        reset;
  logic        oh_valid;
  logic [15:0] one_hot;
  logic        bin_ready;
  logic        err_clr;

  logic        oh_ready, bin_valid, err;
  logic [3:0]  bin;
  logic [1:0]  err_kind;
  logic [7:0]  err_cnt;

  logic        s_oh_ready, s_bin_valid, s_err;
  logic [3:0]  s_bin;
  logic [1:0]  s_kind;
  logic [1:0]  s_cnt;

  onehot_to_bin_stream #(.ONE_HOT_W(16), .BIN_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .oh_valid_i(oh_valid), .oh_ready_o(oh_ready), .one_hot_i(one_hot),
    .bin_valid_o(bin_valid), .bin_ready_i(bin_ready), .bin_o(bin),
    .err_o(err), .err_kind_o(err_kind), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
  );

  onehot_to_bin_stream #(.ONE_HOT_W(16), .BIN_W(4), .ERR_CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .oh_valid_i(oh_valid), .oh_ready_o(s_oh_ready), .one_hot_i(one_hot),
    .bin_valid_o(s_bin_valid), .bin_ready_i(bin_ready), .bin_o(s_bin),
    .err_o(s_err), .err_kind_o(s_kind), .err_cnt_o(s_cnt), .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] oh;
    logic [3:0]  bin;
    logic [1:0]  kind;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    logic [1:0] kind;
    int         pres;
  } exp_t;

  exp_t q[$];
  vec_t tbl[18];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  int   n_acc = 0;
  int   cnt_m = 0;   // model of the 8-bit counter
  int   cnt_s = 0;   // model of the 2-bit counter
  bit   chk_lat = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference encoding from the rules: population count decides the kind,
  // the lowest set bit gives the index.
  task automatic ref_enc(input logic [15:0] d, output logic [3:0] b, output logic [1:0] k);
    int pc;
    pc = $countones(d);
    k  = (pc == 0) ? 2'd1 : ((pc == 1) ? 2'd0 : 2'd2);
    b  = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) b = 4'(i);
    end
  endtask

  // One clock cycle: drive inputs, check combinational/held outputs, score any
  // output transfer, take the edge, record an input transfer, check counters.
  task automatic cycle(input logic v, input logic [15:0] d, input logic rdy,
                       input logic clr, input logic [3:0] eb, input logic [1:0] ek);
    logic exp_ready;
    logic out_x;
    logic e;
    int   pres;
    exp_t f;
    oh_valid  = v;
    one_hot   = d;
    bin_ready = rdy;
    err_clr   = clr;
    pres      = cyc;
    #1;
    exp_ready = (q.size() < 2) || rdy;
    chk("oh_ready", oh_ready, exp_ready);
    chk("small_oh_ready", s_oh_ready, exp_ready);
    if (q.size() == 2) chk("bin_valid_full", bin_valid, 1);
    if (q.size() == 0) chk("bin_valid_empty", bin_valid, 0);
    out_x = bin_valid && rdy;
    e = 1'b0;
    if (out_x && q.size() > 0) begin
      f = q.pop_front();
      chk("bin", bin, f.bin);
      chk("err_kind", err_kind, f.kind);
      chk("err", err, f.kind != 2'd0);
      chk("small_valid", s_bin_valid, 1);
      chk("small_bin", s_bin, f.bin);
      chk("small_kind", s_kind, f.kind);
      chk("small_err", s_err, f.kind != 2'd0);
      if (chk_lat) chk("latency", cyc - f.pres, 2);
      e = (f.kind != 2'd0);
    end
    if (clr) begin
      cnt_m = e ? 1 : 0;
      cnt_s = e ? 1 : 0;
    end else if (e) begin
      cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
      cnt_s = (cnt_s < 3) ? cnt_s + 1 : 3;
    end
    @(posedge clk);
    cyc++;
    if (v && exp_ready) begin
      q.push_back('{eb, ek, pres});
      n_acc++;
    end
    #1;
    chk("err_cnt", err_cnt, cnt_m);
    chk("small_err_cnt", s_cnt, cnt_s);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 2'd0);
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] one16;
    logic [3:0]  eb;
    logic [1:0]  ek;
    int          acc0;
    int          target;

    one16 = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      tbl[i].oh   = one16 << i;
      tbl[i].bin  = 4'(i);
      tbl[i].kind = 2'd0;
    end
    tbl[16] = '{16'h0000, 4'd0, 2'd1};
    tbl[17] = '{16'h0028, 4'd3, 2'd2};

    reset = 1'b1; oh_valid = 1'b0; one_hot = 16'h0000; bin_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_bin", bin, 0);
    chk("rst_err", err, 0);
    chk("rst_err_kind", err_kind, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table: walking one, then zero-hot and multi-hot, full rate.
    chk_lat = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, tbl[i].oh, 1'b1, 1'b0, tbl[i].bin, tbl[i].kind);
    end
    drain();
    chk("table_err_cnt", err_cnt, 2);
    // Empty pipeline keeps the last beat on the outputs.
    chk("idle_valid", bin_valid, 0);
    chk("idle_hold_bin", bin, 3);
    chk("idle_hold_kind", err_kind, 2);
    // Clear with no transfer.
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 2'd0);
    chk("clr_alone", err_cnt, 0);

    // Backpressure: five stalled cycles with valid held high.
    chk_lat = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      d = one16 << (k + 2);
      ref_enc(d, eb, ek);
      cycle(1'b1, d, 1'b0, 1'b0, eb, ek);
    end
    chk("stall_accepts", n_acc - acc0, 2);
    chk("stall_ready_low", oh_ready, 0);
    chk("stall_hold_bin", bin, 2);
    drain();

    // Saturation of the 2-bit counter, then clear coincident with an error.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 2'd1);
    end
    drain();
    chk("small_saturated", s_cnt, 3);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 2'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 2'd0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 2'd0);
    chk("clr_with_err", err_cnt, 1);
    chk("small_clr_with_err", s_cnt, 1);

    // Asynchronous reset with both stages full.
    cycle(1'b1, 16'h0400, 1'b0, 1'b0, 4'd10, 2'd0);
    cycle(1'b1, 16'h0003, 1'b0, 1'b0, 4'd0, 2'd2);
    oh_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bin_valid, 0);
    chk("async_rst_cnt", err_cnt, 0);
    chk("async_rst_small_cnt", s_cnt, 0);
    q.delete();
    cnt_m = 0;
    cnt_s = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_lat = 1'b1;
    cycle(1'b1, 16'h0100, 1'b1, 1'b0, 4'd8, 2'd0);
    drain();
    chk_lat = 1'b0;

    // Randomized valid/ready/clear with mixed vectors.
    target = n_acc + 10000;
    for (int g = 0; g < 40000 && n_acc < target; g++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: d = one16 << $urandom_range(0, 15);
        5:             d = 16'h0000;
        default:       d = 16'($urandom);
      endcase
      ref_enc(d, eb, ek);
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, eb, ek);
    end
    chk("random_beats_done", n_acc >= target, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
